// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

   localparam int unsigned DEF_DATA_BITS = 8;
   localparam int unsigned EDGE_W        = 6;
   localparam int unsigned BIT_W         = 4;

   localparam logic [EDGE_W-1:0] PRESCALE_8  = 6'd8;
   localparam logic [EDGE_W-1:0] PRESCALE_16 = 6'd16;
   localparam logic [EDGE_W-1:0] PRESCALE_32 = 6'd32;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StDone
   } rx_state_e;

   // Index of the final oversampling edge within one bit period.
   function automatic logic [EDGE_W-1:0] last_edge_of(input logic [EDGE_W-1:0] prescale);
      return prescale - 1'b1;
   endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Pin-side and datapath-side signals of the UART receive controller.
interface uart_rx_fsm_if;
   import uart_rx_pkg::*;

   logic              RX_IN;
   logic [EDGE_W-1:0] prescale;
   logic              PAR_EN;
   logic              sample_bit;
   logic              par_err;
   logic              stp_err;

   logic [EDGE_W-1:0] edge_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              data_samp_en;
   logic              deser_en;
   logic              par_chk_en;
   logic              stp_chk_en;
   logic              data_valid;
   logic              frame_err;
   logic              parity_err;

   modport master (
      input  RX_IN, prescale, PAR_EN, sample_bit, par_err, stp_err,
      output edge_cnt, bit_cnt, data_samp_en, deser_en, par_chk_en, stp_chk_en,
             data_valid, frame_err, parity_err
   );

   modport slave (
      output RX_IN, prescale, PAR_EN, sample_bit, par_err, stp_err,
      input  edge_cnt, bit_cnt, data_samp_en, deser_en, par_chk_en, stp_chk_en,
             data_valid, frame_err, parity_err
   );

endinterface

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and frame bit counter; edge wraps at prescale-1.
module edge_bit_counter
   import uart_rx_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic              clr,
   input  logic [EDGE_W-1:0] prescale,
   output logic [EDGE_W-1:0] edge_cnt,
   output logic [BIT_W-1:0]  bit_cnt,
   output logic              last_edge
);

   logic [EDGE_W-1:0] edge_q;
   logic [BIT_W-1:0]  bit_q;

   assign last_edge = (edge_q == last_edge_of(prescale));
   assign edge_cnt  = edge_q;
   assign bit_cnt   = bit_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else if (clr) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else if (en) begin
         if (last_edge) begin
            edge_q <= '0;
            bit_q  <= bit_q + 1'b1;
         end else begin
            edge_q <= edge_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// Frame-level UART receive controller: start detection, bit sequencing, checker strobes
// and one-cycle outcome pulses. Outputs decode only registered state, flags and counters.
module uart_rx_fsm #(
   parameter int unsigned DATA_BITS = uart_rx_pkg::DEF_DATA_BITS
) (
   input logic           CLK,
   input logic           RST,
   uart_rx_fsm_if.master bus
);
   import uart_rx_pkg::*;

   localparam logic [BIT_W-1:0] LastDataBit = BIT_W'(DATA_BITS);

   rx_state_e         state_q, state_d;
   logic [EDGE_W-1:0] prescale_q;
   logic              par_en_q;
   logic              glitch_q;
   logic              par_q;
   logic              stp_q;

   logic [EDGE_W-1:0] edge_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              last_edge;
   logic              counting;
   logic              checkpoint;
   logic              start_entry;
   logic [EDGE_W-1:0] check_edge;

   assign counting    = (state_q == StStart) || (state_q == StData) ||
                        (state_q == StParity) || (state_q == StStop);
   assign check_edge  = last_edge_of(prescale_q) - 1'b1;
   assign checkpoint  = (edge_cnt == check_edge);
   assign start_entry = (state_d == StStart) && ((state_q == StIdle) || (state_q == StDone));

   // Counters sit cleared while idle, so every frame starts from edge 0 / bit 0.
   edge_bit_counter u_counter (
      .CLK       (CLK),
      .RST       (RST),
      .en        (counting),
      .clr       (!counting),
      .prescale  (prescale_q),
      .edge_cnt  (edge_cnt),
      .bit_cnt   (bit_cnt),
      .last_edge (last_edge)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (!bus.RX_IN) state_d = StStart;
         StStart:  if (last_edge) state_d = glitch_q ? StIdle : StData;
         StData: begin
            if (last_edge && (bit_cnt == LastDataBit)) begin
               state_d = par_en_q ? StParity : StStop;
            end
         end
         StParity: if (last_edge) state_d = StStop;
         StStop:   if (last_edge) state_d = StDone;
         StDone:   state_d = bus.RX_IN ? StIdle : StStart;
         default:  state_d = StIdle;
      endcase
   end

   // Frame configuration and checker results captured for the frame in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prescale_q <= PRESCALE_8;
         par_en_q   <= 1'b0;
         glitch_q   <= 1'b0;
         par_q      <= 1'b0;
         stp_q      <= 1'b0;
      end else if (start_entry) begin
         prescale_q <= bus.prescale;
         par_en_q   <= bus.PAR_EN;
         glitch_q   <= 1'b0;
         par_q      <= 1'b0;
         stp_q      <= 1'b0;
      end else begin
         if ((state_q == StStart) && checkpoint) glitch_q <= bus.sample_bit;
         if ((state_q == StParity) && last_edge) par_q <= bus.par_err;
         if ((state_q == StStop) && last_edge) stp_q <= bus.stp_err;
      end
   end

   assign bus.edge_cnt     = edge_cnt;
   assign bus.bit_cnt      = bit_cnt;
   assign bus.data_samp_en = counting;
   assign bus.deser_en     = (state_q == StData) && checkpoint;
   assign bus.par_chk_en   = (state_q == StParity) && checkpoint;
   assign bus.stp_chk_en   = (state_q == StStop) && checkpoint;
   assign bus.frame_err    = ((state_q == StStart) && last_edge && glitch_q) ||
                             ((state_q == StDone) && stp_q);
   assign bus.parity_err   = (state_q == StDone) && !stp_q && par_q;
   assign bus.data_valid   = (state_q == StDone) && !stp_q && !par_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized bench for uart_rx_fsm; expectations come from frame timeline arithmetic.
module tb_uart_rx_fsm;
   import uart_rx_pkg::*;

   logic CLK = 1'b0;
   logic RST;

   uart_rx_fsm_if bus ();

   uart_rx_fsm #(.DATA_BITS(DEF_DATA_BITS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   int unsigned n_stray = 0;

   int          st_deser, st_deser_ok, st_par, st_par_ok, st_stp, st_stp_ok, st_samp;
   int          st_dv, st_fe, st_pe, st_out_r;
   int unsigned st_out_cyc;
   logic [7:0]  st_byte;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   function automatic logic [16:0] outs();
      return {bus.edge_cnt, bus.bit_cnt, bus.data_samp_en, bus.deser_en, bus.par_chk_en,
              bus.stp_chk_en, bus.data_valid, bus.frame_err, bus.parity_err};
   endfunction

   // Line level of frame bit k: start, data LSB first, optional even parity, stop.
   function automatic logic line_bit(input logic [7:0] d, input int k, input bit par_en);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (par_en && k == 9) return ^d;
      return 1'b1;
   endfunction

   task automatic drive_frame(input int r, input int p, input bit par_en, input logic [7:0] d,
                              input bit pv, input bit sv, input bit glitch);
      int nb = par_en ? 11 : 10;
      int k  = (r - 1) / p;
      if (glitch) begin
         bus.RX_IN      = (r >= 2);
         bus.sample_bit = (r >= 2);
      end else begin
         bus.RX_IN      = (r / p < nb) ? line_bit(d, r / p, par_en) : 1'b1;
         bus.sample_bit = (r >= 1 && k < nb) ? line_bit(d, k, par_en) : 1'b1;
      end
      bus.par_err = (r >= 1 && par_en && k == 9) ? pv : 1'($urandom_range(0, 1));
      bus.stp_err = (r >= 1 && k == nb - 1) ? sv : 1'($urandom_range(0, 1));
      if (r >= 1) begin
         bus.prescale = 6'($urandom_range(0, 63));
         bus.PAR_EN   = 1'($urandom_range(0, 1));
      end else begin
         bus.prescale = 6'(p);
         bus.PAR_EN   = par_en;
      end
   endtask

   task automatic observe(input int r, input int p, input int nb);
      int k = r / p;
      if (bus.deser_en) begin
         st_deser++;
         st_byte = {bus.sample_bit, st_byte[7:1]};
         if (r % p == p - 1 && k >= 1 && k <= 8 && bus.edge_cnt == 6'(p - 2) &&
             bus.bit_cnt == 4'(k)) st_deser_ok++;
      end
      if (bus.par_chk_en) begin
         st_par++;
         if (r == 10 * p - 1) st_par_ok++;
      end
      if (bus.stp_chk_en) begin
         st_stp++;
         if (r == nb * p - 1) st_stp_ok++;
      end
      if (bus.data_samp_en) st_samp++;
      if (bus.data_valid) st_dv++;
      if (bus.frame_err) st_fe++;
      if (bus.parity_err) st_pe++;
      if (bus.data_valid || bus.frame_err || bus.parity_err) begin
         st_out_r   = r;
         st_out_cyc = cyc;
      end
   endtask

   task automatic run_frame(input string name, input int p, input bit par_en,
                            input logic [7:0] d, input bit pv, input bit sv, input bit glitch,
                            input int abort_r);
      int nb    = par_en ? 11 : 10;
      int end_r = glitch ? p : 1 + nb * p;
      bit exp_fe, exp_pe, exp_dv;
      if (abort_r > 0) end_r = abort_r;
      {st_deser, st_deser_ok, st_par, st_par_ok, st_stp, st_stp_ok} = '0;
      {st_samp, st_dv, st_fe, st_pe, st_out_r} = '0;
      st_byte = '0;
      drive_frame(0, p, par_en, d, pv, sv, glitch);
      for (int r = 1; r <= end_r; r++) begin
         tick();
         drive_frame(r, p, par_en, d, pv, sv, glitch);
         observe(r, p, nb);
      end
      if (abort_r > 0) begin
         check_eq({name, "/bit_cnt_before_rst"}, 32'(bus.bit_cnt), 32'd4);
         bus.RX_IN = 1'b1;
         RST       = 1'b1;
         #1;
         check_eq({name, "/outs_in_rst"}, 32'(outs()), 32'd0);
         tick();
         RST = 1'b0;
      end else begin
         exp_fe = glitch || sv;
         exp_pe = !exp_fe && par_en && pv;
         exp_dv = !exp_fe && !exp_pe;
         check_eq({name, "/deser_cnt"}, 32'(st_deser), glitch ? 32'd0 : 32'd8);
         check_eq({name, "/deser_timing"}, 32'(st_deser_ok), glitch ? 32'd0 : 32'd8);
         if (!glitch) check_eq({name, "/deser_data"}, 32'(st_byte), 32'(d));
         check_eq({name, "/par_chk"}, 32'(st_par), 32'(!glitch && par_en));
         check_eq({name, "/par_chk_timing"}, 32'(st_par_ok), 32'(!glitch && par_en));
         check_eq({name, "/stp_chk"}, 32'(st_stp), 32'(!glitch));
         check_eq({name, "/stp_chk_timing"}, 32'(st_stp_ok), 32'(!glitch));
         check_eq({name, "/samp_en_cycles"}, 32'(st_samp), glitch ? 32'(p) : 32'(nb * p));
         check_eq({name, "/data_valid"}, 32'(st_dv), 32'(exp_dv));
         check_eq({name, "/frame_err"}, 32'(st_fe), 32'(exp_fe));
         check_eq({name, "/parity_err"}, 32'(st_pe), 32'(exp_pe));
         check_eq({name, "/outcome_cycle"}, 32'(st_out_r), 32'(end_r));
      end
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.RX_IN      = 1'b1;
         bus.sample_bit = 1'($urandom_range(0, 1));
         bus.par_err    = 1'($urandom_range(0, 1));
         bus.stp_err    = 1'($urandom_range(0, 1));
         bus.prescale   = 6'($urandom_range(0, 63));
         bus.PAR_EN     = 1'($urandom_range(0, 1));
         tick();
         if (bus.data_samp_en || bus.deser_en || bus.par_chk_en || bus.stp_chk_en ||
             bus.data_valid || bus.frame_err || bus.parity_err) n_stray++;
      end
   endtask

   initial begin
      int unsigned a_cyc;
      bit          prev_glitch;
      RST            = 1'b1;
      bus.RX_IN      = 1'b1;
      bus.prescale   = PRESCALE_8;
      bus.PAR_EN     = 1'b0;
      bus.sample_bit = 1'b1;
      bus.par_err    = 1'b0;
      bus.stp_err    = 1'b0;
      repeat (2) tick();
      check_eq("reset_outs", 32'(outs()), 32'd0);
      RST = 1'b0;
      idle_ticks(3);

      run_frame("a5_p8", 8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
      idle_ticks(4);
      run_frame("3c_p16_par", 16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 0);
      idle_ticks(4);
      run_frame("glitch_p8", 8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
      idle_ticks(4);
      run_frame("ff_p32_stp", 32, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 0);
      idle_ticks(4);

      run_frame("b2b_55", 16, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 0);
      a_cyc = st_out_cyc;
      run_frame("b2b_aa", 16, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 0);
      check_eq("b2b_gap", st_out_cyc - a_cyc, 32'(10 * 16 + 1));
      idle_ticks(3);

      run_frame("abort", 16, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 4 * 16 + 3);
      idle_ticks(3);
      run_frame("after_abort", 16, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 0);
      idle_ticks(3);

      // Unsupported ratios: only require a return to idle within one long frame.
      for (int j = 0; j < 3; j++) begin
         bus.prescale = (j == 0) ? 6'd5 : (j == 1) ? 6'd1 : 6'd0;
         bus.PAR_EN   = 1'b1;
         bus.RX_IN    = 1'b0;
         tick();
         for (int i = 0; i < 800; i++) begin
            bus.RX_IN      = 1'b1;
            bus.sample_bit = 1'($urandom_range(0, 1));
            bus.par_err    = 1'($urandom_range(0, 1));
            bus.stp_err    = 1'($urandom_range(0, 1));
            tick();
         end
         check_eq("unsupported_back_to_idle", 32'(bus.data_samp_en), 32'd0);
      end
      idle_ticks(2);

      prev_glitch = 1'b1;
      for (int i = 0; i < 24; i++) begin
         int         p;
         bit         g, pen, pv, sv;
         logic [7:0] d;
         case ($urandom_range(0, 2))
            0:       p = 8;
            1:       p = 16;
            default: p = 32;
         endcase
         g   = ($urandom_range(0, 7) == 0);
         pen = 1'($urandom_range(0, 1));
         pv  = 1'($urandom_range(0, 1));
         sv  = ($urandom_range(0, 3) == 0);
         d   = 8'($urandom_range(0, 255));
         if (prev_glitch || $urandom_range(0, 2) != 0) idle_ticks(int'($urandom_range(1, 5)));
         run_frame($sformatf("rand%0d", i), p, pen, d, pv, sv, g, 0);
         prev_glitch = g;
      end
      idle_ticks(5);
      check_eq("stray_pulses", n_stray, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Frame-level controller for the UART receiver. It detects the start edge on RX_IN and runs the edge counter and bit counter. It sequences the enables for the 3-sample majority data sampler, the deserializer and the start, parity and stop checkers. It reports one-cycle frame-done and error pulses. It sits between the RX_IN pin and the RX datapath sub-blocks (data_sampling, deserializer, checkers).

Parameters:
- DATA_BITS, 8, data bits per frame (LSB first).
- EDGE_W, 6, edge counter width. Supports prescale up to 32, with headroom.

Ports:
- CLK  in  1  receiver oversampling clock.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial input (already synchronised upstream).
- prescale  in  6  oversampling ratio. Supported values: 8, 16, 32.
- PAR_EN  in  1  1 = frame carries a parity bit.
- sample_bit  in  1  majority-voted bit from data_sampling.
- par_err  in  1  parity checker result, registered.
- stp_err  in  1  stop checker result, registered.
- edge_cnt  out  6  current edge index within the bit, 0..prescale-1.
- bit_cnt  out  4  current bit index within the frame (0 = start bit).
- data_samp_en  out  1  sampler enable.
- deser_en  out  1  one-cycle shift strobe to the deserializer.
- par_chk_en  out  1  one-cycle parity check strobe.
- stp_chk_en  out  1  one-cycle stop check strobe.
- data_valid  out  1  one-cycle pulse: frame received without error.
- frame_err  out  1  one-cycle pulse: start glitch or stop error.
- parity_err  out  1  one-cycle pulse: parity mismatch.

Behaviour:
- Reset (RST=1, async): state IDLE; edge_cnt=0, bit_cnt=0; all enables and pulses 0. Asserting reset mid-frame aborts the frame; no pulse is emitted.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Counters:
  - Counters run in every state except IDLE and DONE.
  - edge_cnt increments each cycle and wraps at prescale-1 to 0.
  - On wrap, bit_cnt increments.
  - Both counters clear on entry to START.
- Latching: prescale and PAR_EN are latched on IDLE->START. Changes mid-frame are ignored until the next frame.
- data_samp_en is 1 in START, DATA, PARITY and STOP, and 0 otherwise.
- Last edge of a bit: L = latched prescale-1.
- Checkpoint: edge_cnt == L-1. Strobes fire only here. Errors are evaluated at edge_cnt == L.
- IDLE: RX_IN==0 -> START next cycle (edge_cnt=0).
- START:
  - At checkpoint, sample_bit==1 -> start glitch.
  - At L: glitch -> frame_err pulse, go to IDLE. No glitch -> DATA.
- DATA:
  - deser_en pulses at each checkpoint.
  - After DATA_BITS bits (bit_cnt==DATA_BITS at L): -> PARITY if latched PAR_EN, else -> STOP.
- PARITY:
  - par_chk_en pulses at checkpoint.
  - At L: always -> STOP.
  - par_err is sampled at L and remembered internally.
- STOP:
  - stp_chk_en pulses at checkpoint.
  - At L: -> DONE.
- DONE (one cycle):
  - stp_err=1 (sampled at STOP's L) -> frame_err pulse.
  - Else remembered parity error -> parity_err pulse.
  - Else -> data_valid pulse.
  - frame_err has priority over parity_err. Only one of the three pulses fires per frame.
  - Next state: RX_IN==0 -> START (back-to-back frame, counters cleared); else IDLE.
- Latency: RX_IN falls and is sampled low in IDLE at cycle T. The outcome pulse is in cycle T+1+10*P without parity, or T+1+11*P with parity.
- Unsupported prescale (not 8/16/32): timing is unspecified. The FSM must still return to IDLE within one frame length and must never lock up.
- Outputs are registered or decoded from registered state and counters only. There is no combinational path from RX_IN to any output.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE..DONE)
  - DATA_BITS default
  - PRESCALE_8/16/32 constants
  - EDGE_W
- Sub-module edge_bit_counter:
  - Inputs: enable, clear, latched prescale.
  - Outputs: edge_cnt, bit_cnt, last_edge flag.
- The FSM instantiates edge_bit_counter once.

Test Plan:
1. prescale=8, PAR_EN=0, frame 0xA5 sent LSB first. Expected: data_valid pulses in cycle T+81; eight deser_en pulses, each at edge_cnt==6; no error pulses.
2. prescale=16, PAR_EN=1, even-parity frame 0x3C, with par_err driven 1 during PARITY. Expected: parity_err pulse in cycle T+177; data_valid stays 0.
3. Start glitch: RX_IN low for 2 cycles then high, prescale=8. Expected: frame_err pulse at START's edge 7 (cycle T+8); then IDLE; no deser_en pulses.
4. Stop error: prescale=32, frame 0xFF with stp_err=1 during STOP. Expected: frame_err pulse at T+321; no data_valid.
5. Back-to-back frames 0x55 then 0xAA, with RX_IN low in the DONE cycle. Expected: START entered directly; second data_valid exactly 10*P+1 cycles after the first.
6. RST asserted mid-DATA (bit_cnt=4), then released. Expected: all outputs 0 immediately; state IDLE; the next clean frame is received correctly.
